obs_render_multi: RTL and testbench

Renders up to N_OBS horizontally moving obstacles onto the shared VGA raster. This is the parametrised successor of the single-obstacle renderer: it adds configurable sprite size, per-slot sprite type, two-frame animation, and a frame-boundary position latch so that mid-frame game-logic updates do not tear. It sits between the obstacle game logic, the obstacle sprite ROM and the pixel mixer, and outputs one colour bit per pixel with fixed 2-clock latency.

---
 rtl/obs_render_multi.sv | 125 ++++++++++++
 tb/tb_obs_render_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obs_render_multi.sv
// Multi-slot obstacle renderer: frame-latched slot positions, fixed-priority hit select,
// sprite ROM addressing with two-phase animation, 2-clock pixel latency.
module obs_render_multi #(
  parameter int unsigned CONV        = 1,
  parameter int unsigned N_OBS       = 3,
  parameter int unsigned SPR_W       = 8,
  parameter int unsigned SPR_H       = 8,
  parameter int unsigned Y_TOP       = 100,
  parameter int unsigned TYPE_BITS   = 1,
  parameter int unsigned ANIM_FRAMES = 8,
  localparam int unsigned XB = $clog2(SPR_W),
  localparam int unsigned YB = $clog2(SPR_H),
  localparam int unsigned AW = TYPE_BITS + 1 + YB + XB,
  localparam int unsigned IW = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 i_hpos,
  input  logic [9:0]                 i_vpos,
  input  logic [10*N_OBS-1:0]        i_xpos,
  input  logic [N_OBS-1:0]           i_valid,
  input  logic [TYPE_BITS*N_OBS-1:0] i_type,
  output logic [AW-1:0]              o_rom_addr,
  input  logic                       i_sprite_color,
  output logic                       o_color_obs,
  output logic [IW-1:0]              o_obs_id
);

  localparam int unsigned FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  logic                 fs;
  logic [9:0]           sx;
  logic [9:0]           sy;
  logic [10:0]          y_diff;
  logic                 y_in;
  logic [9:0]           xpos_q [N_OBS];
  logic [TYPE_BITS-1:0] type_q [N_OBS];
  logic [N_OBS-1:0]     valid_q;
  logic [FW-1:0]        frame_cnt;
  logic                 anim;
  logic [10:0]          x_diff [N_OBS];
  logic [N_OBS-1:0]     hit;
  logic                 any_hit;
  logic [IW-1:0]        win;
  logic [XB-1:0]        win_x;
  logic [TYPE_BITS-1:0] win_type;
  logic                 hit_q;
  logic [IW-1:0]        id_q;

  assign fs = (i_hpos == 10'd0) && (i_vpos == 10'd0);
  assign sx = i_hpos >> CONV;
  assign sy = i_vpos >> CONV;

  // Subtract with an extra borrow bit so a coordinate left of / above the sprite never wraps
  // around into a hit.
  assign y_diff = {1'b0, sy} - 11'(Y_TOP);
  assign y_in   = !y_diff[10] && (y_diff[9:0] < 10'(SPR_H));

  always_comb begin
    for (int k = 0; k < int'(N_OBS); k++) begin
      x_diff[k] = {1'b0, sx} - {1'b0, xpos_q[k]};
      hit[k]    = valid_q[k] && y_in && !x_diff[k][10] && (x_diff[k][9:0] < 10'(SPR_W));
    end
  end

  // Descending scan so the lowest-index hitting slot is the one left standing.
  always_comb begin
    any_hit  = 1'b0;
    win      = '0;
    win_x    = '0;
    win_type = '0;
    for (int k = int'(N_OBS) - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_hit  = 1'b1;
        win      = IW'(k);
        win_x    = x_diff[k][XB-1:0];
        win_type = type_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      frame_cnt <= '0;
      anim      <= 1'b0;
      for (int k = 0; k < int'(N_OBS); k++) begin
        xpos_q[k] <= '0;
        type_q[k] <= '0;
      end
    end else if (fs) begin
      valid_q <= i_valid;
      for (int k = 0; k < int'(N_OBS); k++) begin
        xpos_q[k] <= i_xpos[10*k +: 10];
        type_q[k] <= i_type[TYPE_BITS*k +: TYPE_BITS];
      end
      if (frame_cnt == FW'(ANIM_FRAMES - 1)) begin
        frame_cnt <= '0;
        anim      <= ~anim;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ROM address holds on misses; only hit_q gates the colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rom_addr  <= '0;
      hit_q       <= 1'b0;
      id_q        <= '0;
      o_color_obs <= 1'b0;
      o_obs_id    <= '0;
    end else begin
      hit_q <= any_hit;
      if (any_hit) begin
        o_rom_addr <= {win_type, anim, y_diff[YB-1:0], win_x};
        id_q       <= win;
      end
      o_color_obs <= hit_q & i_sprite_color;
      o_obs_id    <= id_q;
    end
  end

endmodule

// File: tb/tb_obs_render_multi.sv
// Directed bench for obs_render_multi: default instance plus an unscaled single-slot instance
// used for screen-edge clipping and per-frame animation toggling.
module tb_obs_render_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic [29:0] xpos;
  logic [2:0]  valid;
  logic [2:0]  typ;
  logic [7:0]  rom_addr;
  logic        rom_on;
  logic        color;
  logic [1:0]  obs_id;

  logic [9:0]  c0_xpos;
  logic        c0_valid;
  logic        c0_type;
  logic [7:0]  c0_addr;
  logic        c0_color;
  logic        c0_id;

  int n_vec = 0;
  int n_err = 0;
  int nfs   = 0;

  always #5 clk = ~clk;

  obs_render_multi u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_hpos         (hpos),
    .i_vpos         (vpos),
    .i_xpos         (xpos),
    .i_valid        (valid),
    .i_type         (typ),
    .o_rom_addr     (rom_addr),
    .i_sprite_color (rom_on),
    .o_color_obs    (color),
    .o_obs_id       (obs_id)
  );

  obs_render_multi #(
    .CONV        (0),
    .N_OBS       (1),
    .ANIM_FRAMES (1)
  ) u_dut_c0 (
    .clk            (clk),
    .rst            (rst),
    .i_hpos         (hpos),
    .i_vpos         (vpos),
    .i_xpos         (c0_xpos),
    .i_valid        (c0_valid),
    .i_type         (c0_type),
    .o_rom_addr     (c0_addr),
    .i_sprite_color (rom_on),
    .o_color_obs    (c0_color),
    .o_obs_id       (c0_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    hpos = h;
    vpos = v;
  endtask

  // Hold a pixel long enough that both pipeline stages reflect it.
  task automatic settle(input logic [9:0] h, input logic [9:0] v);
    drive(h, v);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frame_strobe();
    drive(10'd0, 10'd0);
    drive(10'd5, 10'd5);
    nfs++;
  endtask

  task automatic set_slot(input int k, input logic [9:0] x, input logic v, input logic t);
    xpos[10*k +: 10] = x;
    valid[k] = v;
    typ[k] = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    hpos     = 10'd200;
    vpos     = 10'd200;
    xpos     = '0;
    valid    = '0;
    typ      = '0;
    rom_on   = 1'b1;
    c0_xpos  = 10'd1020;
    c0_valid = 1'b1;
    c0_type  = 1'b0;
    set_slot(0, 10'd100, 1'b1, 1'b1);
    set_slot(2, 10'd100, 1'b1, 1'b0);

    // Reset with slots valid and the raster sitting on a would-be hit
    repeat (3) @(negedge clk);
    check_eq("rst_color", color, 0);
    check_eq("rst_id", obs_id, 0);
    check_eq("rst_addr", rom_addr, 0);
    rst = 1'b0;
    settle(10'd200, 10'd200);
    check_eq("pre_fs_color", color, 0);
    check_eq("pre_fs_c0_color", c0_color, 0);

    // Single slot scan of row 200, checked every clock against the 2-clock latency
    set_slot(2, 10'd0, 1'b0, 1'b0);
    frame_strobe();
    for (int h = 190; h <= 232; h++) begin
      @(negedge clk);
      if (h >= 192) check_eq("scan_color", color, (h - 2 >= 200) && (h - 2 <= 215));
      if (h - 1 >= 200 && h - 1 <= 215) begin
        check_eq("scan_addr", rom_addr, 32'h80 + ((h - 1 - 200) >> 1));
        check_eq("scan_id", obs_id, 0);
      end
      hpos = 10'(h);
      vpos = 10'd200;
    end
    rom_on = 1'b0;
    settle(10'd204, 10'd200);
    check_eq("rom_zero_color", color, 0);
    rom_on = 1'b1;
    settle(10'd204, 10'd200);
    check_eq("rom_one_color", color, 1);
    settle(10'd204, 10'd215);
    check_eq("ybot_color", color, 1);
    check_eq("ybot_addr", rom_addr, 32'hBA);
    settle(10'd204, 10'd216);
    check_eq("ybelow_color", color, 0);
    settle(10'd204, 10'd198);
    check_eq("yabove_color", color, 0);

    // Overlap priority
    set_slot(2, 10'd104, 1'b1, 1'b0);
    frame_strobe();
    settle(10'd210, 10'd200);
    check_eq("ovl0_color", color, 1);
    check_eq("ovl0_id", obs_id, 0);
    check_eq("ovl0_addr", rom_addr, 32'h85);
    settle(10'd218, 10'd200);
    check_eq("ovl2_color", color, 1);
    check_eq("ovl2_id", obs_id, 2);
    check_eq("ovl2_addr", rom_addr, 32'h05);
    settle(10'd230, 10'd200);
    check_eq("miss_color", color, 0);
    check_eq("miss_id_hold", obs_id, 2);
    check_eq("miss_addr_hold", rom_addr, 32'h05);

    // Mid-frame position change only takes effect at the next strobe
    set_slot(2, 10'd104, 1'b0, 1'b0);
    frame_strobe();
    drive(10'd0, 10'd150);
    set_slot(0, 10'd300, 1'b1, 1'b1);
    settle(10'd210, 10'd200);
    check_eq("tear_old_color", color, 1);
    check_eq("tear_old_addr", rom_addr, 32'h85);
    settle(10'd600, 10'd200);
    check_eq("tear_new_early", color, 0);
    frame_strobe();
    settle(10'd210, 10'd200);
    check_eq("tear_old_gone", color, 0);
    settle(10'd600, 10'd200);
    check_eq("tear_new_color", color, 1);
    check_eq("tear_new_addr", rom_addr, 32'h80);
    settle(10'd615, 10'd200);
    check_eq("tear_right_color", color, 1);
    check_eq("tear_right_addr", rom_addr, 32'h87);
    settle(10'd616, 10'd200);
    check_eq("tear_past_color", color, 0);

    // Edge clipping, invalid slot, and per-frame toggle on the unscaled instance
    set_slot(0, 10'd1020, 1'b1, 1'b1);
    set_slot(1, 10'd50, 1'b0, 1'b0);
    frame_strobe();
    settle(10'd0, 10'd200);
    check_eq("clip_nowrap", color, 0);
    settle(10'd1023, 10'd200);
    check_eq("clip_offscreen", color, 0);
    settle(10'd100, 10'd200);
    check_eq("invalid_slot", color, 0);
    settle(10'd1019, 10'd100);
    check_eq("c0_left_miss", c0_color, 0);
    settle(10'd1020, 10'd100);
    check_eq("c0_left_hit", c0_color, 1);
    check_eq("c0_left_addr", c0_addr, 32'h40);
    settle(10'd1023, 10'd100);
    check_eq("c0_edge_hit", c0_color, 1);
    check_eq("c0_edge_addr", c0_addr, 32'h43);
    settle(10'd0, 10'd100);
    check_eq("c0_nowrap0", c0_color, 0);
    settle(10'd3, 10'd100);
    check_eq("c0_nowrap3", c0_color, 0);

    set_slot(0, 10'd0, 1'b1, 1'b1);
    c0_xpos = 10'd0;
    frame_strobe();
    settle(10'd14, 10'd200);
    check_eq("x0_hit", color, 1);
    check_eq("x0_addr", rom_addr, 32'h87);
    settle(10'd16, 10'd200);
    check_eq("x0_past", color, 0);
    settle(10'd0, 10'd100);
    check_eq("c0_x0_hit", c0_color, 1);
    check_eq("c0_x0_addr", c0_addr, 32'h00);
    settle(10'd7, 10'd100);
    check_eq("c0_x7_hit", c0_color, 1);
    settle(10'd8, 10'd100);
    check_eq("c0_x8_miss", c0_color, 0);
    settle(10'd1023, 10'd100);
    check_eq("c0_far_miss", c0_color, 0);

    // Animation phase through strobe 17
    while (nfs < 17) begin
      frame_strobe();
      settle(10'd4, 10'd200);
      check_eq("anim_addr", rom_addr, 32'h82 | (((nfs >> 3) & 1) << 6));
    end

    // Reset mid-frame: blank on the next edge, silent until the following strobe
    settle(10'd4, 10'd200);
    check_eq("pre_rst_color", color, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_color", color, 0);
    check_eq("midrst_addr", rom_addr, 0);
    check_eq("midrst_id", obs_id, 0);
    rst = 1'b0;
    settle(10'd4, 10'd200);
    check_eq("post_rst_color", color, 0);
    nfs = 0;
    frame_strobe();
    settle(10'd4, 10'd200);
    check_eq("post_fs_color", color, 1);
    check_eq("post_fs_addr", rom_addr, 32'h82);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
